pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 8, meaning stall cycles per multiply/divide op; legal range 1..255.
REQ-002 SHALL have port Clk  in  1  clock; all state updates on posedge Clk.
REQ-003 SHALL have port Clrn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have ports ex_wreg, ex_m2reg  in  1 each  EX instruction writes a register / is a load.
REQ-007 SHALL have port ex_rd  in  5  destination register of the EX instruction.
REQ-008 SHALL have port id_md_start  in  1  ID instruction is a multiply/divide.
REQ-009 SHALL have port br_taken  in  1  branch/jump in ID resolved taken.
REQ-010 SHALL have ports pc_e, ifid_e  out  1 each  enables for the PC and IF/ID 32-bit enable registers.
REQ-011 SHALL have ports ifid_flush, idex_bubble  out  1 each  load NOP into IF/ID / into ID/EX at next edge.
REQ-012 SHALL have port md_busy  out  1  multiply/divide stall in progress.
REQ-013 SHALL have port stall_cnt  out  16  count of cycles with pc_e low.

Function
REQ-014 SHALL implement states RUN and MD_WAIT plus an 8-bit down-counter md_cnt.
REQ-015 SHALL define lu = ex_wreg & ex_m2reg & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)), combinational.
REQ-016 SHALL, in RUN with lu=1: pc_e=0, ifid_e=0, idex_bubble=1, ifid_flush=0, state unchanged (one-cycle load-use bubble).
REQ-017 SHALL, in RUN with lu=0 and id_md_start=1: pc_e=0, ifid_e=0, idex_bubble=1, next state MD_WAIT, md_cnt loaded with MD_CYCLES-1.
REQ-018 SHALL, in MD_WAIT: pc_e=0, ifid_e=0, idex_bubble=1, md_busy=1; decrement md_cnt each cycle; when md_cnt==0 at the edge, next state RUN.
REQ-019 SHALL, on return to RUN after MD_WAIT, ignore id_md_start for exactly one cycle so the held op issues (no re-trigger).
REQ-020 SHALL, in RUN with lu=0, id_md_start=0 (or masked), br_taken=1: pc_e=1, ifid_e=1, ifid_flush=1, idex_bubble=0.
REQ-021 SHALL, in RUN with no condition active: pc_e=1, ifid_e=1, ifid_flush=0, idex_bubble=0, md_busy=0.
REQ-022 SHALL apply priority load-use > multiply/divide > branch; br_taken SHALL be ignored in MD_WAIT and whenever a stall is asserted.
REQ-023 SHALL make MD_CYCLES=1 give exactly one MD_WAIT cycle (total held-in-ID time MD_CYCLES+1 cycles including the entry cycle).
REQ-024 SHALL increment stall_cnt on each posedge where pc_e=0 and Clrn=1; saturate at 16'hFFFF (no wrap).
REQ-025 SHALL produce outputs combinationally from state and inputs; no output SHALL depend on md_cnt except through state.

Reset
REQ-026 SHALL, while Clrn=0, hold state=RUN, md_cnt=0, stall_cnt=0, and drive pc_e=0, ifid_e=0, ifid_flush=0, idex_bubble=1, md_busy=0.
REQ-027 SHALL, on Clrn asserted during MD_WAIT, abort immediately to RUN; first cycle after release behaves per REQ-021 with idle inputs.
REQ-028 SHALL require no clock edge for reset to take effect; first posedge after Clrn rises is a normal RUN cycle.

Verification
REQ-029 Load-use: ex_m2reg=1, ex_wreg=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle pc_e=0, ifid_e=0, idex_bubble=1; stall_cnt +1.
REQ-030 Zero register: same as REQ-029 with ex_rd=0, id_rs=0 -> no stall, pc_e=1, idex_bubble=0.
REQ-031 Mul/div: MD_CYCLES=8, id_md_start=1 held high -> pc_e low for 9 consecutive cycles, md_busy high 8, then pc_e=1 one cycle with no re-trigger; stall_cnt=9.
REQ-032 Simultaneous: lu=1, id_md_start=1, br_taken=1 -> only load-use bubble (ifid_flush=0, state RUN); next cycle lu=0 -> MD_WAIT entered.
REQ-033 Reset mid-op: Clrn pulsed low at 3rd MD_WAIT cycle -> outputs per REQ-026 immediately, stall_cnt=0, RUN after release.
REQ-034 Saturation: force 65540 stall cycles -> stall_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, multi-cycle multiply/divide
// hold, taken-branch flush and a saturating count of cycles with the PC held.
module pipe_stall_ctrl #(
    parameter int unsigned MD_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rd,
    input  logic        id_md_start,
    input  logic        br_taken,
    output logic        pc_e,
    output logic        ifid_e,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic        md_mask_q, md_mask_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lu;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            md_mask_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_mask_q   <= md_mask_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        lu = ex_wreg & ex_m2reg & (ex_rd != 5'd0) &
             ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        md_mask_d   = 1'b0;
        pc_e        = 1'b1;
        ifid_e      = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;

        case (state_q)
            RUN: begin
                if (lu) begin
                    pc_e        = 1'b0;
                    ifid_e      = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_md_start && !md_mask_q) begin
                    // md_mask_q suppresses re-entry on the cycle the held op finally issues
                    pc_e        = 1'b0;
                    ifid_e      = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = MD_WAIT;
                    md_cnt_d    = 8'(MD_CYCLES - 1);
                end else if (br_taken) begin
                    ifid_flush  = 1'b1;
                end
            end
            MD_WAIT: begin
                pc_e        = 1'b0;
                ifid_e      = 1'b0;
                idex_bubble = 1'b1;
                md_busy     = 1'b1;
                md_cnt_d    = md_cnt_q - 8'd1;
                if (md_cnt_q == 8'd0) begin
                    state_d   = RUN;
                    md_cnt_d  = 8'd0;
                    md_mask_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset forces a safe hold pattern without waiting for a clock edge
        if (!Clrn) begin
            pc_e        = 1'b0;
            ifid_e      = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            md_busy     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_e && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: RUN-state decode table plus multi-cycle
// sequences for multiply/divide hold, priority, reset abort and counter saturation.
module tb_pipe_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rs = 0, id_uses_rt = 0, ex_wreg = 0, ex_m2reg = 0;
    logic        id_md_start = 0, br_taken = 0;
    logic        pc_e, ifid_e, ifid_flush, idex_bubble, md_busy;
    logic [15:0] stall_cnt;

    int total_checks = 0;
    int passed_checks = 0;

    pipe_stall_ctrl #(.MD_CYCLES(8)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
        .id_md_start(id_md_start), .br_taken(br_taken),
        .pc_e(pc_e), .ifid_e(ifid_e), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, rd;
        logic       urs, urt, wreg, m2reg, md, br;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // exp order: {pc_e, ifid_e, ifid_flush, idex_bubble, md_busy}
    task automatic check_outputs(input string name, input logic [4:0] exp);
        check(name, {27'd0, pc_e, ifid_e, ifid_flush, idex_bubble, md_busy}, {27'd0, exp});
    endtask

    task automatic set_idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_wreg = 0; ex_m2reg = 0; id_md_start = 0; br_taken = 0;
    endtask

    task automatic set_load_use();
        ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    endtask

    task automatic apply_reset(input string name);
        @(negedge Clk);
        set_idle();
        Clrn = 0;
        #1;
        check_outputs({name, "_rst_out"}, 5'b00010);
        check({name, "_rst_cnt"}, {16'd0, stall_cnt}, 32'd0);
        @(negedge Clk);
        Clrn = 1;
    endtask

    initial begin
        vecs[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000};
        vecs[1]  = '{"lu_rs",       5, 0, 5, 1, 0, 1, 1, 0, 0, 5'b00010};
        vecs[2]  = '{"zero_reg",    0, 0, 0, 1, 0, 1, 1, 0, 0, 5'b11000};
        vecs[3]  = '{"lu_rt",       0, 7, 7, 0, 1, 1, 1, 0, 0, 5'b00010};
        vecs[4]  = '{"rt_unused",   0, 7, 7, 0, 0, 1, 1, 0, 0, 5'b11000};
        vecs[5]  = '{"not_load",    5, 0, 5, 1, 0, 1, 0, 0, 0, 5'b11000};
        vecs[6]  = '{"branch",      0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11100};
        vecs[7]  = '{"lu_br",       5, 0, 5, 1, 0, 1, 1, 0, 1, 5'b00010};
        vecs[8]  = '{"lu_md_br",    9, 0, 9, 1, 0, 1, 1, 1, 1, 5'b00010};
        vecs[9]  = '{"no_wreg",     5, 0, 5, 1, 0, 0, 1, 0, 0, 5'b11000};
        vecs[10] = '{"rd_mismatch", 5, 0, 6, 1, 0, 1, 1, 0, 1, 5'b11100};

        apply_reset("init");

        for (int i = 0; i < 11; i++) begin
            @(negedge Clk);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            ex_wreg = vecs[i].wreg; ex_m2reg = vecs[i].m2reg;
            id_md_start = vecs[i].md; br_taken = vecs[i].br;
            #1;
            check_outputs(vecs[i].name, vecs[i].exp);
        end

        // Single load-use bubble advances the stall counter by one
        apply_reset("lu");
        set_load_use();
        #1;
        check_outputs("lu_seq_stall", 5'b00010);
        @(negedge Clk);
        set_idle();
        #1;
        check_outputs("lu_seq_resume", 5'b11000);
        check("lu_seq_cnt", {16'd0, stall_cnt}, 32'd1);

        // Multiply/divide held high: 9 held cycles, 8 busy, one issue cycle, then re-arm
        apply_reset("md");
        id_md_start = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge Clk);
            #1;
            check_outputs($sformatf("md_hold_%0d", i), (i == 0) ? 5'b00010 : 5'b00011);
        end
        @(negedge Clk);
        #1;
        check_outputs("md_issue", 5'b11000);
        check("md_cnt9", {16'd0, stall_cnt}, 32'd9);
        @(negedge Clk);
        #1;
        check_outputs("md_rearm", 5'b00010);

        // Load-use beats multiply/divide and branch; MD entered once lu clears
        apply_reset("prio");
        set_load_use();
        id_md_start = 1; br_taken = 1;
        #1;
        check_outputs("prio_lu", 5'b00010);
        @(negedge Clk);
        ex_m2reg = 0;
        #1;
        check_outputs("prio_md_entry", 5'b00010);
        @(negedge Clk);
        #1;
        check_outputs("prio_md_wait", 5'b00011);

        // Reset asserted on the third MD_WAIT cycle aborts immediately
        apply_reset("abort");
        id_md_start = 1;
        repeat (3) @(negedge Clk);
        #1;
        check_outputs("abort_pre", 5'b00011);
        Clrn = 0;
        #1;
        check_outputs("abort_rst_out", 5'b00010);
        check("abort_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge Clk);
        set_idle();
        Clrn = 1;
        #1;
        check_outputs("abort_release", 5'b11000);
        @(negedge Clk);
        #1;
        check_outputs("abort_run", 5'b11000);
        check("abort_cnt", {16'd0, stall_cnt}, 32'd0);

        // Counter saturation under a continuous load-use hazard
        apply_reset("sat");
        set_load_use();
        repeat (65534) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("sat_below", {16'd0, stall_cnt}, 32'hFFFE);
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
        set_idle();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
